btb_update_ctrl: RTL
====================

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter W_PC, default 8, meaning PC tag width.
REQ-002 SHALL have parameter W_BTA, default 32, meaning branch target width.
REQ-003 SHALL have ports clk, input, 1, rising-edge clock.
REQ-004 SHALL have ports reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports lk_valid, input, 1, fetch lookup request this cycle.
REQ-006 SHALL have ports lk_pc, input, W_PC, fetch PC to look up.
REQ-007 SHALL have ports lk_hit, output, 1, registered lookup hit.
REQ-008 SHALL have ports lk_taken, output, 1, registered predicted direction (counter MSB).
REQ-009 SHALL have ports lk_bta, output, W_BTA, registered predicted target.
REQ-010 SHALL have ports up_valid, input, 1, execute-stage resolved-branch update request.
REQ-011 SHALL have ports up_ready, output, 1, controller accepts update this cycle.
REQ-012 SHALL have ports up_pc, input, W_PC, resolved branch PC.
REQ-013 SHALL have ports up_bta, input, W_BTA, resolved branch target.
REQ-014 SHALL have ports up_taken, input, 1, resolved direction.
REQ-015 SHALL have ports flush, input, 1, invalidate all entries.
REQ-016 SHALL have ports stat_lookups, output, 16, lookup count.
REQ-017 SHALL have ports stat_hits, output, 16, hit count.

Function
REQ-018 SHALL own 4 fully-associative entries, each: valid, tag[W_PC], bta[W_BTA], ctr[2], age[2].
REQ-019 Lookup SHALL have 1-cycle latency: lk_* registered from the entry matching lk_pc with valid=1; no match or lk_valid=0 -> lk_hit=0, lk_taken=0, lk_bta=0.
REQ-020 Lookup SHALL be serviced in every state; it sees table contents before any same-edge write.
REQ-021 FSM states SHALL be IDLE, SEARCH, WRITE, FLUSH. up_ready SHALL be 1 only in IDLE with flush=0.
REQ-022 IDLE: up_valid&up_ready -> capture up_* -> SEARCH. SEARCH: match tag, select entry or victim -> WRITE. WRITE: update table -> IDLE. Update occupancy = 3 cycles accept-to-accept.
REQ-023 WRITE hit: ctr saturating +1 if up_taken else -1 (limits 0..3); bta <= up_bta if up_taken.
REQ-024 WRITE miss with up_taken=1: allocate victim: valid=1, tag=up_pc, bta=up_bta, ctr=2'b10. Miss with up_taken=0: no table change.
REQ-025 Victim SHALL be the lowest-index invalid entry; else the entry with age=3.
REQ-026 Touch (lookup hit or WRITE write) of entry e: age[e]<=0; every valid entry with age < old age[e] increments; ages SHALL remain a permutation of 0..3 over valid entries.
REQ-027 Lookup touch and WRITE touch in the same cycle: WRITE touch applied, lookup touch dropped.
REQ-028 Two entries SHALL never hold the same valid tag.
REQ-029 flush=1 in any state -> FLUSH next cycle, aborting any in-flight update; FLUSH clears all valid, ctr, and age -> IDLE. Lookups during FLUSH cycle SHALL return hit=0.

Reset
REQ-030 reset SHALL clear all valid, tag, bta, ctr, age; FSM -> IDLE; lk_hit=0, lk_taken=0, lk_bta=0, up_ready=1 the cycle after reset deasserts, stat_* = 0.
REQ-031 reset SHALL override flush and abort any in-flight update without table writes.

Configuration
REQ-032 With macro BTB_STATS_EN defined, stat_lookups SHALL count accepted lookups and stat_hits SHALL count lookups that hit, each saturating at 16'hFFFF, cleared by reset only.
REQ-033 Without BTB_STATS_EN, stat_lookups and stat_hits SHALL be constant 0 with no counter logic.

Verification
REQ-034 After reset, lookup pc=8'h11 -> next cycle lk_hit=0, lk_bta=0.
REQ-035 Update pc=8'h11, bta=32'h00000011, taken=1; wait 3 cycles; lookup 8'h11 -> lk_hit=1, lk_taken=1, lk_bta=32'h00000011.
REQ-036 Fill 4 entries 8'h10..8'h13, look up 8'h10, allocate 8'h14 -> 8'h11 (age 3) evicted, 8'h10 still hits.
REQ-037 Entry ctr=2'b10, two not-taken updates -> ctr=2'b00, lk_taken=0, lk_hit=1; third not-taken keeps ctr=0.
REQ-038 flush asserted during SEARCH of an update for 8'h22 -> no entry for 8'h22, all lookups miss, up_ready=1 two cycles after flush.
REQ-039 BTB_STATS_EN defined: 5 lookups, 2 hits -> stat_lookups=5, stat_hits=2; undefined -> both 0.

Source files
------------

// File: rtl/btb_update_ctrl_if.sv
// Bundle for the BTB update controller: fetch lookup, execute update, flush, stats.
// Latency: n/a (wiring only).
// Backpressure: up_valid/up_ready handshake on the update channel; lookups are never stalled.
//
// Ports: lk_* (fetch lookup request/response), up_* (resolved-branch update),
// flush (invalidate all), stat_* (lookup/hit counters).
// Modport master = fetch/execute side, slave = controller.
interface btb_update_ctrl_if #(
    parameter int W_PC  = 8,
    parameter int W_BTA = 32
);
    logic              lk_valid;
    logic [W_PC-1:0]   lk_pc;
    logic              lk_hit;
    logic              lk_taken;
    logic [W_BTA-1:0]  lk_bta;

    logic              up_valid;
    logic              up_ready;
    logic [W_PC-1:0]   up_pc;
    logic [W_BTA-1:0]  up_bta;
    logic              up_taken;

    logic              flush;

    logic [15:0]       stat_lookups;
    logic [15:0]       stat_hits;

    modport master (
        output lk_valid, lk_pc, up_valid, up_pc, up_bta, up_taken, flush,
        input  lk_hit, lk_taken, lk_bta, up_ready, stat_lookups, stat_hits
    );

    modport slave (
        input  lk_valid, lk_pc, up_valid, up_pc, up_bta, up_taken, flush,
        output lk_hit, lk_taken, lk_bta, up_ready, stat_lookups, stat_hits
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// 4-entry fully-associative BTB with LRU-age replacement and 2-bit direction counters.
// Latency: lookup 1 cycle (registered); update occupies 3 cycles accept-to-accept.
// Backpressure: up_ready only in IDLE with flush low; lookups serviced every cycle.
//
// Ports: clk (rising edge), reset (synchronous, active-high), bus (btb_update_ctrl_if.slave).
// Optional feature: define BTB_STATS_EN to enable saturating lookup/hit counters;
// without it stat_lookups/stat_hits are tied to zero.
module btb_update_ctrl #(
    parameter int W_PC  = 8,
    parameter int W_BTA = 32
) (
    input  logic               clk,
    input  logic               reset,
    btb_update_ctrl_if.slave   bus
);
    localparam int N_ENT = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_WRITE, ST_FLUSH} state_t;

    // Table state
    logic [N_ENT-1:0]  valid_q;
    logic [W_PC-1:0]   tag_q [N_ENT];
    logic [W_BTA-1:0]  bta_q [N_ENT];
    logic [1:0]        ctr_q [N_ENT];
    logic [1:0]        age_q [N_ENT];
    logic [1:0]        age_d [N_ENT];

    // FSM and captured update
    state_t            state_q;
    logic [W_PC-1:0]   up_pc_q;
    logic [W_BTA-1:0]  up_bta_q;
    logic              up_taken_q;
    logic              sel_hit_q;
    logic [1:0]        sel_idx_q;

    // Registered lookup response
    logic              lk_hit_q;
    logic              lk_taken_q;
    logic [W_BTA-1:0]  lk_bta_q;

    function automatic logic [1:0] first_set(input logic [3:0] v);
        first_set = 2'd0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (v[i]) first_set = 2'(i);
        end
    endfunction

    // ---------------- lookup match ----------------
    logic [N_ENT-1:0] lk_match;
    logic             lk_hit_c;
    logic [1:0]       lk_idx_c;

    always_comb begin
        for (int i = 0; i < N_ENT; i++) begin
            lk_match[i] = valid_q[i] && (tag_q[i] == bus.lk_pc);
        end
        // The FLUSH cycle reports misses even though entries are still valid
        // until the end of that cycle.
        lk_hit_c = bus.lk_valid && (state_q != ST_FLUSH) && (|lk_match);
        lk_idx_c = first_set(lk_match);
    end

    // ---------------- update search ----------------
    logic [N_ENT-1:0] up_match;
    logic [N_ENT-1:0] age3_vec;
    logic [1:0]       victim_idx;

    always_comb begin
        for (int i = 0; i < N_ENT; i++) begin
            up_match[i] = valid_q[i] && (tag_q[i] == up_pc_q);
            age3_vec[i] = valid_q[i] && (age_q[i] == 2'd3);
        end
        if (!(&valid_q)) victim_idx = first_set(~valid_q);
        else             victim_idx = first_set(age3_vec);
    end

    // A miss that is not taken leaves the table untouched; flush aborts the write.
    logic wr_en_c;
    assign wr_en_c = (state_q == ST_WRITE) && !bus.flush && (sel_hit_q || up_taken_q);

    logic [1:0] ctr_next_c;
    always_comb begin
        ctr_next_c = ctr_q[sel_idx_q];
        if (up_taken_q) begin
            if (ctr_q[sel_idx_q] != 2'd3) ctr_next_c = ctr_q[sel_idx_q] + 2'd1;
        end else begin
            if (ctr_q[sel_idx_q] != 2'd0) ctr_next_c = ctr_q[sel_idx_q] - 2'd1;
        end
    end

    // ---------------- age (LRU) maintenance ----------------
    // The table write wins over a same-cycle lookup hit; only one touch per cycle.
    logic       touch_en;
    logic [1:0] touch_idx;
    logic [2:0] touch_old;

    always_comb begin
        touch_en  = wr_en_c || lk_hit_c;
        touch_idx = wr_en_c ? sel_idx_q : lk_idx_c;
        // Allocating into an invalid slot ages every valid entry, so treat its
        // old age as one past the oldest possible.
        touch_old = valid_q[touch_idx] ? {1'b0, age_q[touch_idx]} : 3'd4;
        for (int i = 0; i < N_ENT; i++) begin
            age_d[i] = age_q[i];
            if (touch_en) begin
                if (touch_idx == 2'(i)) begin
                    age_d[i] = 2'd0;
                end else if (valid_q[i] && ({1'b0, age_q[i]} < touch_old)) begin
                    age_d[i] = age_q[i] + 2'd1;
                end
            end
        end
    end

    // ---------------- table storage ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < N_ENT; i++) begin
                tag_q[i] <= '0;
                bta_q[i] <= '0;
                ctr_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else if (state_q == ST_FLUSH) begin
            valid_q <= '0;
            for (int i = 0; i < N_ENT; i++) begin
                ctr_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                age_q[i] <= age_d[i];
            end
            if (wr_en_c) begin
                if (sel_hit_q) begin
                    ctr_q[sel_idx_q] <= ctr_next_c;
                    if (up_taken_q) bta_q[sel_idx_q] <= up_bta_q;
                end else begin
                    valid_q[sel_idx_q] <= 1'b1;
                    tag_q[sel_idx_q]   <= up_pc_q;
                    bta_q[sel_idx_q]   <= up_bta_q;
                    ctr_q[sel_idx_q]   <= 2'b10;
                end
            end
        end
    end

    // ---------------- update FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            up_pc_q    <= '0;
            up_bta_q   <= '0;
            up_taken_q <= 1'b0;
            sel_hit_q  <= 1'b0;
            sel_idx_q  <= 2'd0;
        end else if (bus.flush) begin
            state_q <= ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.up_valid) begin
                        up_pc_q    <= bus.up_pc;
                        up_bta_q   <= bus.up_bta;
                        up_taken_q <= bus.up_taken;
                        state_q    <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    sel_hit_q <= |up_match;
                    sel_idx_q <= (|up_match) ? first_set(up_match) : victim_idx;
                    state_q   <= ST_WRITE;
                end
                ST_WRITE: state_q <= ST_IDLE;
                ST_FLUSH: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.up_ready = (state_q == ST_IDLE) && !bus.flush;

    // ---------------- lookup response ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            lk_hit_q   <= 1'b0;
            lk_taken_q <= 1'b0;
            lk_bta_q   <= '0;
        end else begin
            lk_hit_q   <= lk_hit_c;
            lk_taken_q <= lk_hit_c && ctr_q[lk_idx_c][1];
            lk_bta_q   <= lk_hit_c ? bta_q[lk_idx_c] : '0;
        end
    end

    assign bus.lk_hit   = lk_hit_q;
    assign bus.lk_taken = lk_taken_q;
    assign bus.lk_bta   = lk_bta_q;

    // ---------------- statistics ----------------
`ifdef BTB_STATS_EN
    logic [15:0] stat_lookups_q;
    logic [15:0] stat_hits_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_lookups_q <= '0;
            stat_hits_q    <= '0;
        end else begin
            if (bus.lk_valid && (stat_lookups_q != 16'hFFFF)) stat_lookups_q <= stat_lookups_q + 16'd1;
            if (lk_hit_c && (stat_hits_q != 16'hFFFF))        stat_hits_q    <= stat_hits_q + 16'd1;
        end
    end

    assign bus.stat_lookups = stat_lookups_q;
    assign bus.stat_hits    = stat_hits_q;
`else
    assign bus.stat_lookups = 16'd0;
    assign bus.stat_hits    = 16'd0;
`endif

endmodule
